// File: rtl/multi_channel_aligner_if.sv
// multi_channel_aligner_if: per-channel sample handshake in, aligned frame out
interface multi_channel_aligner_if #(parameter int NCH = 4, parameter int W = 16);
    logic [NCH-1:0]   ch_en, ch_hold, in_valid, in_ready, out_fresh, ovf;
    logic [NCH*W-1:0] in_data, out_data;
    logic             out_valid, out_ready, ovf_clr;
    modport master(output ch_en, ch_hold, in_valid, in_data, out_ready, ovf_clr,
                   input in_ready, out_valid, out_data, out_fresh, ovf);
    modport slave(input ch_en, ch_hold, in_valid, in_data, out_ready, ovf_clr,
                  output in_ready, out_valid, out_data, out_fresh, ovf);
endinterface

// File: rtl/multi_channel_aligner.sv
// multi_channel_aligner: aligns per-channel FIFO samples and sticky hold values into frames
module multi_channel_aligner #(
    parameter int NCH   = 4,
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst,
    multi_channel_aligner_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [NCH-1:0] req, stk, push, pop, hold_vld, fresh_pend, ovf;
    logic [W-1:0]   mem [NCH][DEPTH];
    logic [W-1:0]   hold [NCH];
    logic [AW-1:0]  wp [NCH], rp [NCH];
    logic [AW:0]    cnt [NCH];
    logic           fire;
    assign req     = bus.ch_en & ~bus.ch_hold;
    assign stk     = bus.ch_en & bus.ch_hold;
    assign bus.ovf = ovf;
    always_comb begin
        bus.in_ready  = '1;
        bus.out_data  = '0;
        bus.out_fresh = '0;
        bus.out_valid = |req;
        for (int c = 0; c < NCH; c++) begin
            bus.in_ready[c] = !(req[c] && cnt[c] == FULL);
            if ((req[c] && cnt[c] == '0) || (stk[c] && !hold_vld[c]))
                bus.out_valid = 1'b0;
            bus.out_data[c*W +: W] = req[c] ? mem[c][rp[c]] : stk[c] ? hold[c] : '0;
            bus.out_fresh[c] = req[c] | (stk[c] & fresh_pend[c]);
        end
        fire = bus.out_valid & bus.out_ready;
        push = req & bus.in_valid & bus.in_ready;
        pop  = req & {NCH{fire}};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld   <= '0;
            fresh_pend <= '0;
            ovf        <= '0;
            for (int c = 0; c < NCH; c++) begin
                wp[c]   <= '0;
                rp[c]   <= '0;
                cnt[c]  <= '0;
                hold[c] <= '0;
            end
        end else begin
            ovf <= (ovf & ~{NCH{bus.ovf_clr}}) | (bus.in_valid & ~bus.in_ready);
            for (int c = 0; c < NCH; c++) begin
                // FIFOs only live while the channel is required; any other mode flushes them
                if (!req[c]) begin
                    wp[c]  <= '0;
                    rp[c]  <= '0;
                    cnt[c] <= '0;
                end else begin
                    if (push[c]) wp[c] <= wp[c] + AW'(1);
                    if (pop[c]) rp[c] <= rp[c] + AW'(1);
                    cnt[c] <= cnt[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
                end
                // a sticky write beats the frame-accept clear so the next frame reports it fresh
                if (!bus.ch_en[c]) begin
                    hold_vld[c]   <= 1'b0;
                    fresh_pend[c] <= 1'b0;
                end else if (stk[c] && bus.in_valid[c]) begin
                    hold[c]       <= bus.in_data[c*W +: W];
                    hold_vld[c]   <= 1'b1;
                    fresh_pend[c] <= 1'b1;
                end else if (fire) begin
                    fresh_pend[c] <= 1'b0;
                end
            end
        end
    end
    always_ff @(posedge clk)
        for (int c = 0; c < NCH; c++)
            if (push[c]) mem[c][wp[c]] <= bus.in_data[c*W +: W];
endmodule

// File: tb/tb_multi_channel_aligner.sv
// tb_multi_channel_aligner: vector table plus hand sequences, frames checked by a scoreboard
module tb_multi_channel_aligner;
    localparam int NCH = 4, W = 16, DEPTH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    multi_channel_aligner_if #(.NCH(NCH), .W(W)) bus ();
    multi_channel_aligner #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    typedef struct {
        logic [NCH*W-1:0] data;
        logic [NCH-1:0]   fresh;
    } frame_t;
    typedef struct {
        logic [3:0]  iv;
        logic [63:0] d;
        logic        ordy;
        logic        ev;
        logic        push;
        logic [63:0] ed;
        logic [3:0]  ef;
    } vec_t;
    frame_t sbq[$];
    vec_t   tbl[10];
    int tests = 0, fails = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic expect_frame(input logic [63:0] d, input logic [3:0] f);
        frame_t fr;
        fr.data  = d;
        fr.fresh = f;
        sbq.push_back(fr);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    // inputs are stable at the falling edge, so a frame seen here is accepted at the next rising edge
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sbq.size() == 0) check("unexpected_frame", bus.out_data, 64'h0);
            else begin
                frame_t f;
                f = sbq.pop_front();
                check("frame_data", bus.out_data, f.data);
                check("frame_fresh", {60'h0, bus.out_fresh}, {60'h0, f.fresh});
            end
        end
    end
    initial begin
        tbl[0] = '{4'hE, 64'h0303_0202_0101_0000, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0};
        tbl[1] = '{4'h1, 64'h0000_0000_0000_0040, 1'b0, 1'b1, 1'b1, 64'h0303_0202_0101_0040, 4'hF};
        tbl[2] = '{4'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0};
        tbl[3] = '{4'hE, 64'h0333_0222_0111_0000, 1'b0, 1'b1, 1'b1, 64'h0333_0222_0111_0040, 4'hE};
        tbl[4] = '{4'h1, 64'h0000_0000_0000_0050, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0};
        tbl[5] = '{4'hE, 64'h1113_1112_1111_0000, 1'b0, 1'b1, 1'b1, 64'h1113_1112_1111_0050, 4'hF};
        tbl[6] = '{4'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0};
        tbl[7] = '{4'hE, 64'h0AA3_0AA2_0AA1_0000, 1'b0, 1'b1, 1'b1, 64'h0AA3_0AA2_0AA1_0050, 4'hE};
        tbl[8] = '{4'hE, 64'h0BB3_0BB2_0BB1_0000, 1'b1, 1'b1, 1'b1, 64'h0BB3_0BB2_0BB1_0050, 4'hE};
        tbl[9] = '{4'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 4'h0};
        bus.ch_en = 4'hF;
        bus.ch_hold = 4'h1;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        bus.ovf_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst_valid", {63'h0, bus.out_valid}, 64'h0);
        check("rst_ovf", {60'h0, bus.ovf}, 64'h0);
        check("rst_ready", {60'h0, bus.in_ready}, 64'hF);
        check("rst_fresh", {60'h0, bus.out_fresh}, 64'hE);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid  = tbl[i].iv;
            bus.in_data   = tbl[i].d;
            bus.out_ready = tbl[i].ordy;
            if (tbl[i].push) expect_frame(tbl[i].ed, tbl[i].ef);
            step();
            check($sformatf("tbl%0d_valid", i), {63'h0, bus.out_valid}, {63'h0, tbl[i].ev});
        end
        // overflow on ch1 with the consumer stalled
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 4'h2;
            bus.in_data  = 64'(32'h0A00 + k) << 16;
            step();
            check($sformatf("fill%0d_ready1", k), {63'h0, bus.in_ready[1]}, {63'h0, k < 3});
        end
        check("fill_ovf", {60'h0, bus.ovf}, 64'h0);
        step();
        check("ovf_set", {60'h0, bus.ovf}, 64'h2);
        bus.in_valid = 4'h0;
        bus.ovf_clr = 1'b1;
        step();
        check("ovf_clr", {60'h0, bus.ovf}, 64'h0);
        bus.in_valid = 4'h2;
        step();
        check("ovf_set_wins", {60'h0, bus.ovf}, 64'h2);
        bus.in_valid = 4'h0;
        step();
        bus.ovf_clr = 1'b0;
        check("ovf_clr2", {60'h0, bus.ovf}, 64'h0);
        check("ovf_no_frame", {63'h0, bus.out_valid}, 64'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        // reset with three samples buffered per required channel
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 4'hE;
            bus.in_data  = {16'(16'h0B30 + k), 16'(16'h0B20 + k), 16'(16'h0B10 + k), 16'h0};
            step();
        end
        bus.in_valid = 4'h1;
        bus.in_data  = 64'h77;
        step();
        check("pre_rst_valid", {63'h0, bus.out_valid}, 64'h1);
        bus.in_valid = 4'h0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("post_rst_valid", {63'h0, bus.out_valid}, 64'h0);
        check("post_rst_ovf", {60'h0, bus.ovf}, 64'h0);
        check("post_rst_ready", {60'h0, bus.in_ready}, 64'hF);
        bus.in_valid = 4'hF;
        bus.in_data  = 64'h0C03_0C02_0C01_0C00;
        expect_frame(64'h0C03_0C02_0C01_0C00, 4'hF);
        step();
        check("post_rst_frame", {63'h0, bus.out_valid}, 64'h1);
        bus.in_valid = 4'h0;
        bus.out_ready = 1'b1;
        step();
        check("post_rst_drain", {63'h0, bus.out_valid}, 64'h0);
        // skewed arrival: ch1 leads ch2/ch3 by three cycles
        bus.in_valid = 4'h2;
        bus.in_data  = 64'h0000_0000_0D01_0000;
        step();
        check("skew0", {63'h0, bus.out_valid}, 64'h0);
        bus.in_valid = 4'h0;
        step();
        check("skew1", {63'h0, bus.out_valid}, 64'h0);
        step();
        check("skew2", {63'h0, bus.out_valid}, 64'h0);
        bus.in_valid = 4'hC;
        bus.in_data  = 64'h0D03_0D02_0000_0000;
        expect_frame(64'h0D03_0D02_0D01_0C00, 4'hE);
        step();
        check("skew_valid", {63'h0, bus.out_valid}, 64'h1);
        bus.in_valid = 4'h0;
        step();
        check("skew_drained", {63'h0, bus.out_valid}, 64'h0);
        check("skew_ready", {60'h0, bus.in_ready}, 64'hF);
        // disable ch2 with two samples buffered
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 4'hE;
            bus.in_data  = {16'(16'h0E30 + k), 16'(16'h0E20 + k), 16'(16'h0E10 + k), 16'h0};
            step();
        end
        check("dis_pre_valid", {63'h0, bus.out_valid}, 64'h1);
        bus.in_valid = 4'h0;
        bus.ch_en = 4'hB;
        #1;
        check("dis_slice", {48'h0, bus.out_data[47:32]}, 64'h0);
        check("dis_fresh", {60'h0, bus.out_fresh}, 64'hA);
        expect_frame(64'h0E30_0000_0E10_0C00, 4'hA);
        expect_frame(64'h0E31_0000_0E11_0C00, 4'hA);
        step();
        bus.out_ready = 1'b1;
        step();
        step();
        check("dis_drained", {63'h0, bus.out_valid}, 64'h0);
        check("dis_ready2", {63'h0, bus.in_ready[2]}, 64'h1);
        bus.ch_en = 4'hF;
        bus.in_valid = 4'hE;
        bus.in_data  = 64'h0F30_0F20_0F10_0000;
        expect_frame(64'h0F30_0F20_0F10_0C00, 4'hE);
        step();
        check("reen_valid", {63'h0, bus.out_valid}, 64'h1);
        bus.in_valid = 4'h0;
        step();
        check("reen_drained", {63'h0, bus.out_valid}, 64'h0);
        check("sb_empty", 64'(sbq.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
